conv_mac_engine: RTL and testbench

CONV_MAC_ENGINE -- requirements
Module: conv_mac_engine

---
 rtl/conv_mac_engine.sv | 199 +++++++++++++++++++
 tb/tb_conv_mac_engine.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_mac_engine.sv
// conv_mac_engine
//   Sequential convolution multiply-accumulate engine. Each accepted beat
//   carries one K x K patch and its kernel for one input channel; the engine
//   adds one tap product per clock. After CH beats the accumulated value
//   (bias + all products) is saturated to OW bits, optionally ReLU-clamped,
//   and presented on a valid/ready output.
//
// Parameters
//   K        kernel edge size (K*K taps)
//   DW       signed pixel / weight width
//   CH       input channels accumulated per output pixel
//   OW       signed output width (OW <= AW)
//   RELU_EN  1: negative results are clamped to zero
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   a channel beat is offered
//   in_ready   engine can accept a beat (high only in IDLE)
//   in_patch   signed pixels, tap t = row*K+col in bits [t*DW +: DW]
//   in_kernel  signed weights, same packing as in_patch
//   in_bias    signed bias, used only on the first beat of a pixel
//   out_valid  out_data holds a result
//   out_ready  downstream accepts the result
//   out_data   saturated (and optionally ReLU-clamped) result
//   busy       high unless idle with no partially accumulated pixel

module conv_mac_engine #(
  parameter int K       = 3,
  parameter int DW      = 8,
  parameter int CH      = 1,
  parameter int OW      = 16,
  parameter int RELU_EN = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [K*K*DW-1:0]    in_patch,
  input  logic [K*K*DW-1:0]    in_kernel,
  input  logic [2*DW-1:0]      in_bias,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OW-1:0]        out_data,
  output logic                 busy
);

  localparam int NT = K * K;
  // Wide enough for bias plus NT*CH full-scale products, so it never wraps.
  localparam int AW = 2 * DW + $clog2(NT * CH) + 1;
  localparam int TW = (NT > 1) ? $clog2(NT) : 1;
  localparam int CW = (CH > 1) ? $clog2(CH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MAC,
    S_OUT
  } state_t;

  state_t                r_state;
  state_t                w_state_next;

  logic [NT*DW-1:0]      r_patch;
  logic [NT*DW-1:0]      r_kernel;
  logic [TW-1:0]         r_tap;
  logic [CW-1:0]         r_ch_cnt;
  logic signed [AW-1:0]  r_acc;
  logic                  r_out_valid;
  logic [OW-1:0]         r_out_data;

  logic                  w_accept;
  logic                  w_last_tap;
  logic                  w_last_ch;
  logic signed [DW-1:0]  w_pix;
  logic signed [DW-1:0]  w_wgt;
  logic signed [2*DW-1:0] w_prod;
  logic signed [AW-1:0]  w_prod_ext;
  logic signed [AW-1:0]  w_bias_ext;
  logic [AW-OW:0]        w_hi;
  logic [OW-1:0]         w_result;

  assign w_accept   = (r_state == S_IDLE) && in_valid;
  assign w_last_tap = (r_tap == TW'(NT - 1));
  assign w_last_ch  = (r_ch_cnt == CW'(CH - 1));

  // One tap per cycle, selected by the tap index from the latched beat.
  assign w_pix      = r_patch[r_tap*DW +: DW];
  assign w_wgt      = r_kernel[r_tap*DW +: DW];
  assign w_prod     = w_pix * w_wgt;
  assign w_prod_ext = {{(AW - 2*DW){w_prod[2*DW-1]}}, w_prod};
  assign w_bias_ext = {{(AW - 2*DW){in_bias[2*DW-1]}}, in_bias};

  // The value fits in OW bits exactly when all bits from OW-1 upward agree.
  assign w_hi = r_acc[AW-1:OW-1];

  always_comb begin
    w_result = r_acc[OW-1:0];
    if (r_acc[AW-1] && !(&w_hi)) begin
      w_result = {1'b1, {(OW-1){1'b0}}};
    end else if (!r_acc[AW-1] && (|w_hi)) begin
      w_result = {1'b0, {(OW-1){1'b1}}};
    end
    if ((RELU_EN != 0) && w_result[OW-1]) begin
      w_result = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_state_next = S_MAC;
        end
      end
      S_MAC: begin
        if (w_last_tap) begin
          w_state_next = w_last_ch ? S_OUT : S_IDLE;
        end
      end
      S_OUT: begin
        if (r_out_valid && out_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // NOTE: the latched operands are plain data captured on every accept and
  // never read before being written, so they carry no reset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_patch  <= in_patch;
      r_kernel <= in_kernel;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tap       <= '0;
      r_ch_cnt    <= '0;
      r_acc       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_tap <= '0;
            // Bias seeds the accumulator only on the first channel beat.
            if (r_ch_cnt == '0) begin
              r_acc <= w_bias_ext;
            end
          end
        end
        S_MAC: begin
          r_acc <= r_acc + w_prod_ext;
          if (!w_last_tap) begin
            r_tap <= r_tap + TW'(1);
          end else if (!w_last_ch) begin
            r_ch_cnt <= r_ch_cnt + CW'(1);
          end
        end
        S_OUT: begin
          // First OUT cycle registers the finished result; afterwards the
          // result is held until the consumer takes it.
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_result;
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
            r_ch_cnt    <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign busy      = !((r_state == S_IDLE) && (r_ch_cnt == '0));

endmodule

// File: tb/tb_conv_mac_engine.sv
// tb_conv_mac_engine
//   Directed bench for conv_mac_engine. Four instances share one clock/reset:
//     0: K=3 CH=1 RELU_EN=0   1: K=3 CH=1 RELU_EN=1
//     2: K=3 CH=4 RELU_EN=0   3: K=1 CH=1 RELU_EN=0
//   Expected results come from a dot-product/saturation model; a scoreboard
//   process compares out_data on every cycle out_valid is high.

module tb_conv_mac_engine;

  localparam int NT = 9;
  localparam int PW = NT * 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [PW-1:0]   patch;
  logic [PW-1:0]   kernel;
  logic [7:0]      k1_patch;
  logic [7:0]      k1_kernel;
  logic [15:0]     bias;
  logic [3:0]      in_valid;
  logic [3:0]      out_ready;
  wire  [3:0]      in_ready;
  wire  [3:0]      out_valid;
  wire  [3:0]      busy;
  wire  [3:0][15:0] out_data;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int exp_q[4][$];

  conv_mac_engine #(.K(3), .DW(8), .CH(1), .OW(16), .RELU_EN(0)) u_base (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_patch(patch), .in_kernel(kernel), .in_bias(bias),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
    .busy(busy[0]));

  conv_mac_engine #(.K(3), .DW(8), .CH(1), .OW(16), .RELU_EN(1)) u_relu (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_patch(patch), .in_kernel(kernel), .in_bias(bias),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
    .busy(busy[1]));

  conv_mac_engine #(.K(3), .DW(8), .CH(4), .OW(16), .RELU_EN(0)) u_mc (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_patch(patch), .in_kernel(kernel), .in_bias(bias),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_data(out_data[2]),
    .busy(busy[2]));

  conv_mac_engine #(.K(1), .DW(8), .CH(1), .OW(16), .RELU_EN(0)) u_k1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[3]), .in_ready(in_ready[3]),
    .in_patch(k1_patch), .in_kernel(k1_kernel), .in_bias(bias),
    .out_valid(out_valid[3]), .out_ready(out_ready[3]), .out_data(out_data[3]),
    .busy(busy[3]));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- model ----------------
  function automatic longint dot(input logic [PW-1:0] p, input logic [PW-1:0] k,
                                 input int n);
    longint s = 0;
    for (int t = 0; t < n; t++) begin
      s += longint'($signed(p[t*8 +: 8])) * longint'($signed(k[t*8 +: 8]));
    end
    return s;
  endfunction

  function automatic int sat_relu(input longint v, input bit relu);
    longint r = v;
    if (r > 32767) r = 32767;
    else if (r < -32768) r = -32768;
    if (relu && r < 0) r = 0;
    return int'(r);
  endfunction

  function automatic logic [PW-1:0] fill(input logic [7:0] v);
    return {NT{v}};
  endfunction

  function automatic logic [PW-1:0] ramp();
    logic [PW-1:0] r;
    for (int t = 0; t < NT; t++) r[t*8 +: 8] = 8'(t);
    return r;
  endfunction

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        if (out_valid[i]) begin
          if (exp_q[i].size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL sb%0d_unexpected: got out_valid=1 data %0d, expected no result",
                     i, $signed(out_data[i]));
          end else begin
            check($sformatf("sb%0d_data", i), $signed(out_data[i]), exp_q[i][0]);
          end
        end
      end
    end
  end

  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        if (out_valid[i] && out_ready[i] && exp_q[i].size() > 0) begin
          void'(exp_q[i].pop_front());
        end
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic scramble();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    patch = r[PW-1:0];
    r = {$urandom, $urandom, $urandom};
    kernel = r[PW-1:0];
    k1_patch = r[79:72];
    k1_kernel = r[87:80];
    bias = r[95:80];
  endtask

  // Offers one beat on instance i; returns the number of the accepting edge.
  task automatic send(input int i, input logic [PW-1:0] p, input logic [PW-1:0] k,
                      input logic [15:0] b, output int acc_edge);
    int n = 0;
    if (i == 3) begin
      k1_patch = p[7:0];
      k1_kernel = k[7:0];
    end else begin
      patch = p;
      kernel = k;
    end
    bias = b;
    in_valid[i] = 1'b1;
    while (!in_ready[i] && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready[i]) check($sformatf("accept_timeout%0d", i), in_ready[i], 1);
    acc_edge = cyc + 1;
    @(negedge clk);
    in_valid[i] = 1'b0;
    scramble();
  endtask

  task automatic wait_valid(input int i, output int edge_seen);
    int n = 0;
    while (!out_valid[i] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid[i]) check($sformatf("valid_timeout%0d", i), out_valid[i], 1);
    edge_seen = cyc;
  endtask

  task automatic drain(input int i, input int hold);
    repeat (hold) begin
      check($sformatf("hold_in_ready%0d", i), in_ready[i], 0);
      @(negedge clk);
    end
    out_ready[i] = 1'b1;
    @(negedge clk);
    out_ready[i] = 1'b0;
    check($sformatf("after_hs_valid%0d", i), out_valid[i], 0);
    check($sformatf("after_hs_busy%0d", i), busy[i], 0);
  endtask

  // Full single-beat pixel on instance i with latency and literal checks.
  task automatic pixel(input string name, input int i, input logic [PW-1:0] p,
                       input logic [PW-1:0] k, input logic [15:0] b, input int lit,
                       output int acc_edge);
    int seen;
    int lat;
    exp_q[i].push_back(sat_relu(longint'($signed(b)) + dot(p, k, (i == 3) ? 1 : NT),
                                i == 1));
    send(i, p, k, b, acc_edge);
    check({name, "_in_ready_mac"}, in_ready[i], 0);
    check({name, "_busy_mac"}, busy[i], 1);
    wait_valid(i, seen);
    lat = (i == 3) ? 2 : NT + 1;
    check({name, "_latency"}, seen - acc_edge, lat);
    check({name, "_literal"}, $signed(out_data[i]), lit);
    drain(i, 2);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int ae;
    int first;
    int seen;
    int rel;
    longint acc;

    in_valid = '0;
    out_ready = '0;
    scramble();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rst_out_valid%0d", i), out_valid[i], 0);
      check($sformatf("rst_out_data%0d", i), out_data[i], 0);
      check($sformatf("rst_busy%0d", i), busy[i], 0);
    end
    rst = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) check($sformatf("rst_in_ready%0d", i), in_ready[i], 1);
    @(negedge clk);

    // Basic pixel and saturation at both rails.
    pixel("basic", 0, fill(8'd1), fill(8'd2), 16'd5, 23, ae);
    pixel("sat_neg", 0, fill(8'h80), fill(8'h7f), 16'd0, -32768, ae);
    pixel("sat_pos", 0, fill(8'h80), fill(8'h80), 16'd0, 32767, ae);
    pixel("neg_noclamp", 0, fill(8'hff), ramp(), 16'hfff6, -46, ae);

    // ReLU variant.
    pixel("relu_sat", 1, fill(8'h80), fill(8'h7f), 16'd0, 0, ae);
    pixel("relu_pos", 1, fill(8'd3), ramp(), 16'hfff6, 98, ae);
    pixel("relu_small_neg", 1, fill(8'hff), ramp(), 16'hfff6, 0, ae);

    // Four-channel accumulation; later biases must be ignored.
    acc = 7;
    for (int b = 0; b < 4; b++) acc += dot(fill(8'd1), fill(8'd1), NT);
    exp_q[2].push_back(sat_relu(acc, 1'b0));
    for (int b = 0; b < 4; b++) begin
      if (b > 0) begin
        int n = 0;
        while (!in_ready[2] && n < 50) begin
          @(negedge clk);
          n++;
        end
        check("mc_ready_between", in_ready[2], 1);
        check("mc_busy_between", busy[2], 1);
      end
      send(2, fill(8'd1), fill(8'd1), (b == 0) ? 16'd7 : 16'd99, ae);
      if (b == 0) first = ae;
      check("mc_ready_in_mac", in_ready[2], 0);
    end
    wait_valid(2, seen);
    check("mc_latency", seen - first, 4 * (NT + 1));
    check("mc_literal", $signed(out_data[2]), 43);
    drain(2, 0);

    // Backpressure: result held, input offers ignored, single handshake.
    exp_q[0].push_back(sat_relu(100 + dot(ramp(), fill(8'hfe), NT), 1'b0));
    send(0, ramp(), fill(8'hfe), 16'd100, ae);
    wait_valid(0, seen);
    for (int c = 0; c < 5; c++) begin
      in_valid[0] = 1'b1;
      check("bp_in_ready", in_ready[0], 0);
      check("bp_valid", out_valid[0], 1);
      check("bp_literal", $signed(out_data[0]), 28);
      @(negedge clk);
      scramble();
    end
    in_valid[0] = 1'b0;
    out_ready[0] = 1'b1;
    @(negedge clk);
    out_ready[0] = 1'b0;
    check("bp_released", out_valid[0], 0);
    pixel("bp_next", 0, fill(8'd2), fill(8'd3), 16'hfffc, 50, ae);

    // Reset while a result waits in OUT: it must never appear.
    exp_q[0].push_back(sat_relu(dot(fill(8'd4), fill(8'd4), NT), 1'b0));
    send(0, fill(8'd4), fill(8'd4), 16'd0, ae);
    wait_valid(0, seen);
    rst = 1'b1;
    exp_q[0].delete();
    #1;
    check("rst_out_valid_clr", out_valid[0], 0);
    check("rst_out_data_clr", out_data[0], 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset at MAC tap 4, then a clean pixel accepted on the first edge.
    send(0, fill(8'd5), fill(8'd7), 16'd100, ae);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midmac_out_valid", out_valid[0], 0);
    check("midmac_out_data", out_data[0], 0);
    check("midmac_busy", busy[0], 0);
    @(negedge clk);
    rst = 1'b0;
    rel = cyc;
    #1;
    check("midmac_in_ready", in_ready[0], 1);
    pixel("post_rst", 0, fill(8'd1), fill(8'd1), 16'd0, 9, ae);
    check("post_rst_first_edge", ae, rel + 1);

    // Degenerate K=1.
    pixel("k1_basic", 3, {64'd0, 8'hf9}, {64'd0, 8'h09}, 16'd3, -60, ae);
    pixel("k1_sat", 3, {64'd0, 8'h7f}, {64'd0, 8'h7f}, 16'h7fff, 32767, ae);

    repeat (12) @(negedge clk);
    for (int i = 0; i < 4; i++) check($sformatf("end_queue%0d", i), exp_q[i].size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
